// File: rtl/display_pkg.sv
// Shared types and constants for the hex display path: arbiter state encoding,
// requester count, hex width and small index helpers.
package display_pkg;

    localparam int unsigned NumReq   = 3;
    localparam int unsigned HexWidth = 24;
    localparam int unsigned CntWidth = 8;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StHold = 1'b1
    } disp_state_e;

    typedef logic [NumReq-1:0]   req_t;
    typedef logic [HexWidth-1:0] hex_t;
    typedef logic [1:0]          req_idx_t;
    typedef logic [CntWidth-1:0] cnt_t;

    // Last-winner value after reset; makes requester 0 the first in line.
    localparam req_idx_t LastInit = 2'd2;

    // A hold of zero ticks is treated as one; anything above the counter range saturates.
    function automatic cnt_t hold_limit(input int unsigned ticks);
        if (ticks == 0) return cnt_t'(1);
        if (ticks > 255) return cnt_t'(255);
        return cnt_t'(ticks);
    endfunction

    function automatic req_idx_t rr_next(input req_idx_t last, input int unsigned step);
        return req_idx_t'((32'(last) + step) % NumReq);
    endfunction

    function automatic req_idx_t onehot_to_idx(input req_t oh);
        req_idx_t idx;
        idx = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (oh[i]) idx = req_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/display_arbiter_if.sv
// Requester/display-side bundle of the display arbiter: requests, offered values,
// hold strobe, grant acknowledge and the value shown on the display.
interface display_arbiter_if;
    import display_pkg::*;

    logic tick;
    req_t req;
    hex_t val0;
    hex_t val1;
    hex_t val2;
    req_t grant;
    hex_t hex_out;
    logic busy;

    modport master (
        output tick, req, val0, val1, val2,
        input  grant, hex_out, busy
    );

    modport slave (
        input  tick, req, val0, val1, val2,
        output grant, hex_out, busy
    );

endinterface

// File: rtl/display_arbiter_rr_pick.sv
// Combinational round-robin selector: first active request after the last winner,
// returned as a one-hot code plus a valid flag.
module rr_pick
    import display_pkg::*;
(
    input  req_t     req,
    input  req_idx_t last,
    output req_t     winner,
    output logic     valid
);

    req_idx_t idx;

    always_comb begin
        winner = '0;
        idx    = '0;
        for (int unsigned k = 1; k <= NumReq; k++) begin
            idx = rr_next(last, k);
            if (winner == '0 && req[idx]) winner[idx] = 1'b1;
        end
    end

    assign valid = |winner;

endmodule

// File: rtl/display_arbiter.sv
// Arbitrates three hex-value requesters onto one display, holding each captured
// value for a minimum number of refresh ticks.
module display_arbiter
    import display_pkg::*;
#(
    parameter int unsigned HOLD_TICKS = 4
) (
    input logic              clk,
    input logic              rst,
    display_arbiter_if.slave bus
);

    localparam cnt_t Limit = hold_limit(HOLD_TICKS);

    disp_state_e state_q, state_d;
    cnt_t        cnt_q, cnt_d;
    req_idx_t    last_q, last_d;
    hex_t        hex_q, hex_d;
    req_t        grant_q, grant_d;

    req_t winner;
    logic win_valid;

    rr_pick u_rr_pick (
        .req    (bus.req),
        .last   (last_q),
        .winner (winner),
        .valid  (win_valid)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        hex_d   = hex_q;
        grant_d = '0;
        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    grant_d = winner;
                    cnt_d   = '0;
                    last_d  = onehot_to_idx(winner);
                    state_d = StHold;
                    unique case (winner)
                        3'b001:  hex_d = bus.val0;
                        3'b010:  hex_d = bus.val1;
                        3'b100:  hex_d = bus.val2;
                        default: hex_d = hex_q;
                    endcase
                end
            end
            StHold: begin
                // Requests and values are ignored here; only ticks move the window on.
                if (bus.tick) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d >= Limit) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            last_q  <= LastInit;
            hex_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            hex_q   <= hex_d;
            grant_q <= grant_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.hex_out = hex_q;
    assign bus.busy    = (state_q == StHold);

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter: grant scoreboard plus directed hold,
// reset and idle checks on a default build and a HOLD_TICKS=0 build.
module tb_display_arbiter;
    import display_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    display_arbiter_if bus ();
    display_arbiter_if zbus ();

    display_arbiter #(.HOLD_TICKS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    display_arbiter #(.HOLD_TICKS(0)) dut_z (
        .clk (clk),
        .rst (rst),
        .bus (zbus)
    );

    typedef struct packed {
        req_t grant;
        hex_t hex;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   n;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic expect_grant(input req_t g, input hex_t h);
        exp_t e;
        e.grant = g;
        e.hex   = h;
        exp_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int budget, output int cycles);
        cycles = 0;
        do begin
            cyc();
            cycles++;
        end while (bus.grant == '0 && cycles < budget);
        check("grant_wait", 32'(bus.grant != '0), 32'd1);
    endtask

    // Scoreboard: every grant seen on the main DUT must match the next expected entry.
    always @(negedge clk) begin
        if (bus.grant !== '0) begin
            check("grant_onehot", 32'($countones(bus.grant)), 32'd1);
            if (exp_q.size() == 0) begin
                check("grant_unexpected", 32'(bus.grant), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("grant", 32'(bus.grant), 32'(mon_e.grant));
                check("grant_hex", 32'(bus.hex_out), 32'(mon_e.hex));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        bus.tick  = 1'b0;
        bus.req   = '0;
        bus.val0  = '0;
        bus.val1  = '0;
        bus.val2  = '0;
        zbus.tick = 1'b0;
        zbus.req  = '0;
        zbus.val0 = '0;
        zbus.val1 = '0;
        zbus.val2 = '0;
        repeat (2) cyc();
        check("rst_hex", 32'(bus.hex_out), 32'h0);
        check("rst_grant", 32'(bus.grant), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_z_busy", 32'(zbus.busy), 32'h0);
        rst = 1'b0;

        // First capture, with a tick coincident with the capture edge.
        bus.req  = 3'b001;
        bus.val0 = 24'hFEDCBA;
        bus.tick = 1'b1;
        expect_grant(3'b001, 24'hFEDCBA);
        cyc();
        check("cap_busy", 32'(bus.busy), 32'd1);
        check("cap_hex", 32'(bus.hex_out), 32'hFEDCBA);
        bus.req  = '0;
        bus.tick = 1'b0;
        bus.val0 = 24'h000000;
        for (int i = 1; i <= 4; i++) begin
            bus.tick = 1'b1;
            cyc();
            bus.tick = 1'b0;
            check("hold_busy", 32'(bus.busy), 32'(i < 4));
            check("hold_hex", 32'(bus.hex_out), 32'hFEDCBA);
            cyc();
            check("hold_grant", 32'(bus.grant), 32'h0);
        end
        check("idle_hex", 32'(bus.hex_out), 32'hFEDCBA);

        // HOLD_TICKS=0 behaves as one tick; the capture-cycle tick is ignored.
        zbus.req  = 3'b001;
        zbus.val0 = 24'hABCDEF;
        zbus.tick = 1'b1;
        cyc();
        check("z_cap_busy", 32'(zbus.busy), 32'd1);
        check("z_cap_grant", 32'(zbus.grant), 32'b001);
        check("z_cap_hex", 32'(zbus.hex_out), 32'hABCDEF);
        zbus.req  = '0;
        zbus.tick = 1'b0;
        cyc();
        check("z_wait_busy", 32'(zbus.busy), 32'd1);
        check("z_wait_grant", 32'(zbus.grant), 32'h0);
        zbus.tick = 1'b1;
        cyc();
        zbus.tick = 1'b0;
        check("z_end_busy", 32'(zbus.busy), 32'd0);

        // Round robin with all requesters active and back-to-back holds.
        rst = 1'b1;
        cyc();
        rst      = 1'b0;
        bus.req  = 3'b111;
        bus.val0 = 24'h111111;
        bus.val1 = 24'h222222;
        bus.val2 = 24'h333333;
        bus.tick = 1'b1;
        expect_grant(3'b001, 24'h111111);
        expect_grant(3'b010, 24'h222222);
        expect_grant(3'b100, 24'h333333);
        expect_grant(3'b001, 24'h111111);
        wait_grant(10, n);
        check("rr_latency", 32'(n), 32'd1);
        for (int i = 0; i < 3; i++) begin
            wait_grant(20, n);
            check("rr_spacing", 32'(n), 32'd5);
        end
        bus.req = '0;
        repeat (4) cyc();
        bus.tick = 1'b0;
        check("rr_end_busy", 32'(bus.busy), 32'd0);

        // Value and request changes during a hold are ignored.
        bus.req  = 3'b001;
        bus.val0 = 24'hAAAAAA;
        expect_grant(3'b001, 24'hAAAAAA);
        cyc();
        check("chg_cap_hex", 32'(bus.hex_out), 32'hAAAAAA);
        bus.val0 = 24'h0F0F0F;
        bus.val1 = 24'h555555;
        bus.req  = 3'b011;
        expect_grant(3'b010, 24'h555555);
        expect_grant(3'b001, 24'h0F0F0F);
        for (int i = 1; i <= 4; i++) begin
            bus.tick = 1'b1;
            cyc();
            bus.tick = 1'b0;
            check("chg_hold_hex", 32'(bus.hex_out), 32'hAAAAAA);
        end
        wait_grant(3, n);
        check("chg_regrant_lat", 32'(n), 32'd1);
        bus.tick = 1'b1;
        wait_grant(10, n);
        check("chg_fair_spacing", 32'(n), 32'd5);
        bus.req = '0;
        repeat (4) cyc();
        bus.tick = 1'b0;
        check("chg_end_busy", 32'(bus.busy), 32'd0);

        // Reset mid-hold, asserted together with requests and a tick.
        bus.req  = 3'b001;
        bus.val0 = 24'h123456;
        expect_grant(3'b001, 24'h123456);
        cyc();
        bus.req  = '0;
        bus.tick = 1'b1;
        repeat (2) cyc();
        bus.tick = 1'b0;
        check("mid_busy", 32'(bus.busy), 32'd1);
        rst      = 1'b1;
        bus.req  = 3'b110;
        bus.val1 = 24'h777777;
        bus.val2 = 24'h888888;
        bus.tick = 1'b1;
        cyc();
        check("mid_rst_hex", 32'(bus.hex_out), 32'h0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_grant", 32'(bus.grant), 32'h0);
        rst      = 1'b0;
        bus.tick = 1'b0;
        expect_grant(3'b010, 24'h777777);
        wait_grant(3, n);
        check("post_rst_lat", 32'(n), 32'd1);
        bus.req  = '0;
        bus.tick = 1'b1;
        repeat (4) cyc();
        bus.tick = 1'b0;
        check("post_rst_end_busy", 32'(bus.busy), 32'd0);

        // Long idle keeps the last captured value.
        for (int i = 0; i < 50; i++) begin
            cyc();
            check("idle_hold_hex", 32'(bus.hex_out), 32'h777777);
            check("idle_grant", 32'(bus.grant), 32'h0);
            check("idle_busy", 32'(bus.busy), 32'd0);
        end

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter: HOLD_TICKS, default 4, minimum number of tick strobes a granted value stays on the display; legal range 1..255, and a value of 0 SHALL behave as 1.
REQ-002 Port: clk  input  1  single system clock; all logic on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: tick  input  1  one-cycle hold-time strobe from the display refresh divider.
REQ-005 Port: req  input  3  per-requester display request; bit i belongs to requester i.
REQ-006 Port: val0, val1, val2  input  24 each  six-nibble hex value offered by requesters 0, 1 and 2.
REQ-007 Port: grant  output  3  one-hot, one-cycle acknowledge that the value was captured.
REQ-008 Port: hex_out  output  24  value driven to the display driver's hex input.
REQ-009 Port: busy  output  1  high while a granted value is in its hold window.

Function
REQ-010 The FSM SHALL have two states, IDLE and HOLD; busy SHALL be 1 exactly when the state is HOLD.
REQ-011 Capture: in IDLE with req != 0 at a rising edge, the block SHALL, at that edge, load hex_out with the winner's value, set grant to the winner's one-hot code, clear the tick counter and enter HOLD.
REQ-012 Latency: grant and the new hex_out SHALL appear in the cycle after req is first sampled high in IDLE, i.e. one clock of latency.
REQ-013 Arbitration: the winner SHALL be the first requester with req high, searching in order last+1, last+2, last+3 (mod 3), where last is the previous winner.
REQ-014 The last-winner pointer SHALL update only on a capture.
REQ-015 grant SHALL be 0 in every cycle except the single capture cycle, and SHALL never have more than one bit set.
REQ-016 In HOLD, hex_out SHALL remain stable, and req and val changes SHALL be ignored.
REQ-017 In HOLD, each tick SHALL increment the counter.
REQ-018 The tick that brings the count to HOLD_TICKS SHALL return the FSM to IDLE at that edge.
REQ-019 A tick arriving in the capture cycle SHALL NOT be counted; counting starts in the first HOLD cycle.
REQ-020 Back-to-back: if req is still high in the first IDLE cycle after HOLD, a new capture SHALL occur on that edge. IDLE therefore lasts a minimum of one cycle between holds.
REQ-021 In IDLE with req == 0, hex_out SHALL retain its last captured value.
REQ-022 A requester holding req high after its grant SHALL compete again under the normal round-robin order, with no special priority.
REQ-023 The counter width SHALL be 8 bits; the counter SHALL not wrap within a hold window.

Reset
REQ-024 When rst is sampled high, the block SHALL force state=IDLE, hex_out=24'h000000, grant=3'b000, busy=0, counter=0 and last=2, so that requester 0 wins first.
REQ-025 Reset asserted mid-HOLD SHALL abort the hold on that edge; no grant SHALL be issued in the reset cycle.
REQ-026 rst SHALL take priority over req and tick in the same cycle.

Structure
REQ-027 A shared display_pkg SHALL hold the state encoding, the requester count (3) and the hex width (24); the display driver SHALL use the same package.
REQ-028 One sub-module, rr_pick, SHALL be used: a combinational round-robin selector taking req and last and returning a one-hot winner plus a valid flag.
REQ-029 All outputs SHALL be registered.

Verification
REQ-030 Reset, then req=3'b001 with val0=24'hFEDCBA -> one cycle later hex_out=FEDCBA, grant=001, busy=1; busy falls on the 4th tick.
REQ-031 req=3'b111 held, val0/1/2 = 111111/222222/333333 -> grants in order 001, 010, 100, 001, each separated by a 4-tick hold.
REQ-032 During HOLD, change val0 to 0F0F0F and raise req[1] -> hex_out unchanged until the hold ends, then grant=010.
REQ-033 HOLD_TICKS=0 build -> busy drops on the first counted tick; a tick coincident with the capture cycle is not counted.
REQ-034 rst pulsed after 2 ticks of HOLD -> next cycle hex_out=000000, busy=0; with req=3'b110 afterwards, the next grant is 010.
REQ-035 req=000 for 50 cycles after a hold -> hex_out holds its last value, grant stays 000, busy stays 0.
